// File: rtl/mips_pkg.sv
// mips_pkg: shared types and widths for the multicycle MIPS memory interface.
`default_nettype none

package mips_pkg;

    localparam int WORD_W      = 32;
    localparam int BYTE_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mips_mem_array.sv
// ============================================================================
// Module   : mips_mem_array
// Brief    : DEPTH_WORDS x 32 storage, one synchronous write port and one
//            registered read port whose output can be forced to zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_mem_array
    import mips_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Storage has no reset: contents survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module   : mips_mem_responder
// Brief    : Unified instruction/data memory responder with programmable wait
//            states. Define MIPS_MEM_ERR_CHECK_EN to reject misaligned and
//            out-of-range requests with rsp_err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [BYTE_ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [WORD_W-1:0]      rsp_rdata,
    output logic                   rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t             state;
    mem_state_t             next_state;
    logic [3:0]             wait_cnt;
    logic                   lat_write;
    logic [BYTE_ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0]      lat_wdata;

    logic                   accept;
    logic                   enter_resp;
    logic                   eff_write;
    logic [BYTE_ADDR_W-1:0] eff_addr;
    logic [WORD_W-1:0]      eff_wdata;
    logic                   addr_err;

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            if (accept) begin
                wait_cnt  <= CNT_INIT;
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // With no wait states the array is accessed on the accepting edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    always_comb begin
        eff_write = (state == IDLE) ? req_write : lat_write;
        eff_addr  = (state == IDLE) ? req_addr  : lat_addr;
        eff_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    end

    assign enter_resp = (next_state == RESP);

`ifdef MIPS_MEM_ERR_CHECK_EN
    assign addr_err = (|eff_addr[1:0]) || (|eff_addr[BYTE_ADDR_W-1:IDX_W+2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else if (enter_resp) begin
            rsp_err <= addr_err;
        end
    end
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{eff_addr[1:0], eff_addr[BYTE_ADDR_W-1:IDX_W+2]};
    assign addr_err         = 1'b0;
    assign rsp_err          = 1'b0;
`endif

    mips_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enter_resp && eff_write && !addr_err),
        .rd_en   (enter_resp),
        .rd_zero (eff_write || addr_err),
        .idx     (eff_addr[IDX_W+1:2]),
        .wdata   (eff_wdata),
        .rdata   (rsp_rdata)
    );

endmodule

`default_nettype wire
